fu_div: RTL and testbench

- Fixed-latency iterative integer divider functional unit (RV32M DIV/DIVU/REM/REMU).
- Sits directly downstream of the ID-stage control unit, which issues it through DIV_en.
- The control unit schedules DIV write-back a fixed LATENCY cycles after issue. The unit therefore guarantees its result is stable at exactly that cycle and holds it until the next issue.
- Operands arrive from ID-stage register read; res is consumed by the write-back mux when write_sel selects DIV.

---
 rtl/fu_div_pkg.sv | 24 ++
 rtl/div_step2.sv | 25 ++
 rtl/fu_div.sv | 149 ++++++++++++++
 tb/tb_fu_div.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fu_div_pkg.sv
// rtl/fu_div_pkg.sv - shared encodings and latency for the integer divide unit
// DIV_LATENCY is also consumed by the control unit's write-back delay table.
package fu_div_pkg;

   localparam int DIV_LATENCY = 24;

   localparam logic [1:0] DIVOP_DIV  = 2'b00;
   localparam logic [1:0] DIVOP_DIVU = 2'b01;
   localparam logic [1:0] DIVOP_REM  = 2'b10;
   localparam logic [1:0] DIVOP_REMU = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      CALC,
      FIX,
      WAIT,
      DONE
   } div_state_t;

   function automatic logic [31:0] neg_if(input logic [31:0] v, input logic n);
      return n ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/div_step2.sv
// rtl/div_step2.sv - two chained restoring divide steps, two quotient bits per call
// The partial remainder is always below the divisor, so one spare bit covers the shift.
module div_step2 (
   input  logic [31:0] rem,
   input  logic [31:0] divisor,
   input  logic [1:0]  bits,
   output logic [31:0] rem_next,
   output logic [1:0]  q
);

   logic [32:0] t1;
   logic [32:0] t2;
   logic [31:0] r1;

   always_comb begin
      q        = 2'b00;
      t1       = {rem, bits[1]};
      q[1]     = (t1 >= {1'b0, divisor});
      r1       = q[1] ? 32'(t1 - {1'b0, divisor}) : t1[31:0];
      t2       = {r1, bits[0]};
      q[0]     = (t2 >= {1'b0, divisor});
      rem_next = q[0] ? 32'(t2 - {1'b0, divisor}) : t2[31:0];
   end

endmodule

// File: rtl/fu_div.sv
// rtl/fu_div.sv - fixed-latency iterative RV32M divider (DIV/DIVU/REM/REMU)
// Result appears exactly LATENCY edges after issue and is held until the next issue.
module fu_div
   import fu_div_pkg::*;
#(
   parameter int LATENCY = DIV_LATENCY,
   parameter int XLEN    = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        EN,
   input  logic [1:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [31:0] res,
   output logic        finish,
   output logic        busy
);

   if (LATENCY < 18 || LATENCY > 31) begin : g_bad_latency
      $error("fu_div: LATENCY must lie in 18..31");
   end
   if (XLEN != 32) begin : g_bad_xlen
      $error("fu_div: only XLEN=32 is supported");
   end

   localparam logic [4:0] LAT5 = 5'(LATENCY);

   div_state_t  state;
   logic [4:0]  cnt;
   logic        sel_rem;
   logic        neg_q;
   logic        neg_r;
   logic        div_zero;
   logic        ovf;
   logic [31:0] a_raw;
   logic [31:0] divisor;
   logic [31:0] dvd;
   logic [31:0] rem;
   logic [31:0] quot;
   logic [31:0] result;

   logic        is_signed;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] step_rem;
   logic [1:0]  step_q;
   logic [31:0] q_final;
   logic [31:0] r_final;

   div_step2 u_step (
      .rem      (rem),
      .divisor  (divisor),
      .bits     (dvd[31:30]),
      .rem_next (step_rem),
      .q        (step_q)
   );

   always_comb begin
      is_signed = (op == DIVOP_DIV) || (op == DIVOP_REM);
      a_neg     = is_signed & A[31];
      b_neg     = is_signed & B[31];
      a_mag     = neg_if(A, a_neg);
      b_mag     = neg_if(B, b_neg);
   end

   // Special cases override the magnitude datapath; it produces garbage for them.
   always_comb begin
      q_final = neg_if(quot, neg_q);
      r_final = neg_if(rem, neg_r);
      if (div_zero) begin
         q_final = 32'hFFFF_FFFF;
         r_final = a_raw;
      end else if (ovf) begin
         q_final = 32'h8000_0000;
         r_final = 32'h0000_0000;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= 5'd0;
         sel_rem  <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         ovf      <= 1'b0;
         a_raw    <= 32'd0;
         divisor  <= 32'd0;
         dvd      <= 32'd0;
         rem      <= 32'd0;
         quot     <= 32'd0;
         result   <= 32'd0;
         res      <= 32'd0;
         finish   <= 1'b0;
         busy     <= 1'b0;
      end else begin
         if (state != IDLE && cnt != LAT5) begin
            cnt <= cnt + 5'd1;
         end
         // A new issue always wins, including over a result due this same edge.
         if (EN) begin
            state    <= CALC;
            cnt      <= 5'd1;
            sel_rem  <= (op == DIVOP_REM) || (op == DIVOP_REMU);
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= (B == 32'd0);
            ovf      <= is_signed && (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
            a_raw    <= A;
            divisor  <= b_mag;
            dvd      <= a_mag;
            rem      <= 32'd0;
            quot     <= 32'd0;
            busy     <= 1'b1;
            finish   <= 1'b0;
         end else begin
            case (state)
               CALC: begin
                  rem  <= step_rem;
                  quot <= {quot[29:0], step_q};
                  dvd  <= {dvd[29:0], 2'b00};
                  if (cnt == 5'd16) begin
                     state <= FIX;
                  end
               end
               FIX: begin
                  result <= sel_rem ? r_final : q_final;
                  state  <= WAIT;
               end
               WAIT: begin
                  if (cnt == LAT5) begin
                     res    <= result;
                     finish <= 1'b1;
                     busy   <= 1'b0;
                     state  <= DONE;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fu_div.sv
// tb/tb_fu_div.sv - scoreboard bench for fu_div against an arithmetic reference model
module tb_fu_div;

   localparam int LAT = 24;

   logic        clk = 1'b0;
   logic        rst;
   logic        EN;
   logic [1:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic [31:0] res;
   logic        finish;
   logic        busy;

   fu_div #(.LATENCY(LAT), .XLEN(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .EN     (EN),
      .op     (op),
      .A      (A),
      .B      (B),
      .res    (res),
      .finish (finish),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] exp;
      int          at_edge;
      string       name;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          mon_k;
   logic        have_last = 1'b0;
   logic [31:0] last_res = 32'd0;

   always @(posedge clk) cyc <= cyc + 1;

   // op bit0 = unsigned, bit1 = remainder; signed math in 64 bits, truncated to 32.
   function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      longint da, db, q, r;
      if (b == 32'd0) begin
         return o[1] ? a : 32'hFFFF_FFFF;
      end
      if (o[0]) begin
         da = longint'({32'd0, a});
         db = longint'({32'd0, b});
      end else begin
         da = longint'($signed(a));
         db = longint'($signed(b));
      end
      q = da / db;
      r = da % db;
      return o[1] ? r[31:0] : q[31:0];
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (sb.size() > 0) begin
            mon_k = cyc - sb[0].at_edge;
            if (mon_k < LAT) begin
               chk({sb[0].name, "_busy"}, 32'(busy), 32'd1);
               chk({sb[0].name, "_finish_early"}, 32'(finish), 32'd0);
            end else begin
               chk({sb[0].name, "_finish"}, 32'(finish), 32'd1);
               chk({sb[0].name, "_busy_low"}, 32'(busy), 32'd0);
               chk({sb[0].name, "_res"}, res, sb[0].exp);
               last_res  = sb[0].exp;
               have_last = 1'b1;
               void'(sb.pop_front());
            end
         end else begin
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_finish", 32'(finish), 32'(have_last));
            chk("idle_res_hold", res, have_last ? last_res : 32'd0);
         end
      end
   end

   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string nm);
      exp_t e;
      @(negedge clk);
      EN = 1'b1;
      op = o;
      A  = a;
      B  = b;
      @(posedge clk);
      if (sb.size() > 0) void'(sb.pop_back());
      e.exp     = ref_div(o, a, b);
      e.at_edge = cyc + 1;
      e.name    = nm;
      sb.push_back(e);
      @(negedge clk);
      EN = 1'b0;
      A  = $urandom;
      B  = $urandom;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (sb.size() > 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL timeout: %s got no finish, expected one within %0d cycles", sb[0].name, LAT);
         sb.delete();
      end
   endtask

   initial begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      rst = 1'b1;
      EN  = 1'b0;
      op  = 2'b00;
      A   = 32'd0;
      B   = 32'd0;
      repeat (3) @(negedge clk);
      chk("reset_res", res, 32'd0);
      chk("reset_finish", 32'(finish), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      rst = 1'b0;

      issue(2'b01, 32'd100, 32'd7, "divu_100_7");
      wait_done();
      repeat (16) @(negedge clk);
      issue(2'b10, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
      wait_done();
      issue(2'b00, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
      wait_done();
      issue(2'b00, 32'd5, 32'd0, "div_5_0");
      wait_done();
      issue(2'b11, 32'd5, 32'd0, "remu_5_0");
      wait_done();
      issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      wait_done();
      issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
      wait_done();
      issue(2'b01, 32'hFFFF_FFFF, 32'd1, "divu_max_1");
      wait_done();
      issue(2'b11, 32'hFFFF_FFFF, 32'h0001_0000, "remu_max_64k");
      wait_done();

      issue(2'b01, 32'd100, 32'd7, "aborted");
      repeat (8) @(negedge clk);
      issue(2'b01, 32'd81, 32'd9, "restart_81_9");
      wait_done();

      issue(2'b01, 32'd100, 32'd7, "aborted_at_finish");
      repeat (22) @(negedge clk);
      issue(2'b01, 32'd1000, 32'd10, "restart_on_finish_edge");
      wait_done();

      issue(2'b01, 32'd100, 32'd7, "reset_victim");
      repeat (11) @(negedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      sb.delete();
      have_last = 1'b0;
      #1;
      chk("async_rst_res", res, 32'd0);
      chk("async_rst_finish", 32'(finish), 32'd0);
      chk("async_rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      issue(2'b01, 32'd1000, 32'd7, "after_reset");
      wait_done();

      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: rb = 32'hFFFF_FFFF;
            2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            3: rb = 32'($urandom_range(1, 300));
            4: rb = rb >> $urandom_range(8, 31);
            default: ;
         endcase
         issue(ro, ra, rb, "rand");
         if ($urandom_range(0, 5) == 0) begin
            repeat ($urandom_range(0, 20)) @(negedge clk);
            issue(2'($urandom_range(0, 3)), $urandom, 32'($urandom_range(1, 1000)), "rand_restart");
         end
         wait_done();
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      repeat (4) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at time %0t, expected completion earlier", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
